// File: rtl/secret_digit_gen.sv
// secret_digit_gen: draws four mutually distinct decimal digits (n1..n4)
// from a free-running 16-bit Galois LFSR mixed with a 1-bit entropy input.
// Out-of-range and duplicate candidates are rejected; after MAX_TRIES
// rejects at one position the smallest unused digit is taken instead, so
// a secret is always ready within 4*(MAX_TRIES+1) cycles of the start edge.
// Optional build macro: LEADING_NONZERO_EN keeps n1 away from 0.
module secret_digit_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [7:0]  MAX_TRIES = 8'd255
) (
  input  logic       clk,
  input  logic       enb,
  input  logic       start,
  input  logic       entropy,
  output logic [3:0] n1,
  output logic [3:0] n2,
  output logic [3:0] n3,
  output logic [3:0] n4,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [1:0]  r_idx;
  logic [7:0]  r_tries;
  logic [3:0]  r_dig [4];
  logic        r_valid;
  logic        r_busy;

  logic [15:0] w_lfsr_next;
  logic [3:0]  w_cand;
  logic        w_accept;
  logic        w_take;
  logic [3:0]  w_fallback;
  logic [3:0]  w_digit;

  // One Galois step (mask B400, shift right), entropy into bit 0, and
  // reload the seed rather than ever sitting in the all-zero lock-up state.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l, input logic e);
    logic [15:0] t;
    t    = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    t[0] = t[0] ^ e;
    return (t == 16'h0000) ? SEED : t;
  endfunction

  // A digit is blocked at position idx when an earlier position holds it;
  // with the leading-nonzero build, 0 is also blocked at position 0.
  function automatic logic digit_blocked(input logic [3:0] c, input logic [1:0] idx,
                                         input logic [3:0] d0, input logic [3:0] d1,
                                         input logic [3:0] d2);
    logic b;
    b = ((idx >= 2'd1) && (c == d0)) ||
        ((idx >= 2'd2) && (c == d1)) ||
        ((idx == 2'd3) && (c == d2));
`ifdef LEADING_NONZERO_EN
    b = b || ((idx == 2'd0) && (c == 4'd0));
`endif
    return b;
  endfunction

  // Smallest digit 0..9 not blocked at idx; at most four values are ever
  // blocked, so a free digit always exists.
  function automatic logic [3:0] first_free(input logic [1:0] idx, input logic [3:0] d0,
                                            input logic [3:0] d1, input logic [3:0] d2);
    logic [3:0] r;
    r = 4'd9;
    for (int v = 9; v >= 0; v--) begin
      r = digit_blocked(4'(v), idx, d0, d1, d2) ? r : 4'(v);
    end
    return r;
  endfunction

  // Candidate evaluation: accept, retry, or fall back for the current position.
  always_comb begin
    w_lfsr_next = lfsr_step(r_lfsr, entropy);
    w_cand      = r_lfsr[3:0];
    w_accept    = (w_cand <= 4'd9) &&
                  !digit_blocked(w_cand, r_idx, r_dig[0], r_dig[1], r_dig[2]);
    w_fallback  = first_free(r_idx, r_dig[0], r_dig[1], r_dig[2]);
    w_take      = w_accept || (r_tries == MAX_TRIES);
    if (w_accept) begin
      w_digit = w_cand;
    end else begin
      w_digit = w_fallback;
    end
  end

  // LFSR free-run plus the IDLE/DRAW/DONE control with registered outputs.
  always_ff @(posedge clk) begin
    if (enb) begin
      r_lfsr  <= SEED;
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_tries <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_DRAW;
            r_idx   <= 2'd0;
            r_tries <= 8'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
          end
        end
        ST_DRAW: begin
          if (w_take) begin
            r_dig[r_idx] <= w_digit;
            r_tries      <= 8'd0;
            if (r_idx == 2'd3) begin
              r_state <= ST_DONE;
              r_idx   <= 2'd0;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else begin
            r_tries <= r_tries + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
          r_tries <= 8'd0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign n1    = r_dig[0];
  assign n2    = r_dig[1];
  assign n3    = r_dig[2];
  assign n4    = r_dig[3];
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule
